stream_onehot_demux: RTL



---
 rtl/stream_onehot_demux.sv | 79 +++++++
 1 files changed

// File: rtl/stream_onehot_demux.sv
// One-deep registered demux: routes each beat to the port named by its one-hot selector, 1-cycle latency, full throughput.
// Non-one-hot beats are swallowed and reported through err_sel / err_count; a stalled port blocks all ports.
module stream_onehot_demux #(
  parameter int N_OUTPUTS = 2,
  parameter int W_DATA    = 32,
  parameter int W_ERRCNT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_DATA-1:0]    in_data,
  input  logic [N_OUTPUTS-1:0] in_sel,
  output logic [N_OUTPUTS-1:0] out_valid,
  input  logic [N_OUTPUTS-1:0] out_ready,
  output logic [W_DATA-1:0]    out_data,
  output logic                 err_sel,
  output logic [W_ERRCNT-1:0]  err_count
);

  logic                 full_q, full_d;
  logic [W_DATA-1:0]    data_q, data_d;
  logic [N_OUTPUTS-1:0] dest_q, dest_d;
  logic                 err_sel_q, err_sel_d;
  logic [W_ERRCNT-1:0]  err_cnt_q, err_cnt_d;

  logic drain;
  logic acc;
  logic sel_ok;

  // Only the ready of the addressed port matters; others are ignored.
  assign drain    = full_q & (|(dest_q & out_ready));
  assign in_ready = ~full_q | drain;
  assign acc      = in_valid & in_ready;
  assign sel_ok   = (in_sel != '0) && ((in_sel & (in_sel - N_OUTPUTS'(1))) == '0);

  always_comb begin
    full_d    = full_q;
    data_d    = data_q;
    dest_d    = dest_q;
    err_sel_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (acc && sel_ok) begin
      full_d = 1'b1;
      data_d = in_data;
      dest_d = in_sel;
    end else if (acc) begin
      full_d    = full_q & ~drain;
      err_sel_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + W_ERRCNT'(1);
      end
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 1'b0;
      data_q    <= '0;
      dest_q    <= '0;
      err_sel_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      err_sel_q <= err_sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = dest_q & {N_OUTPUTS{full_q}};
  assign out_data  = data_q;
  assign err_sel   = err_sel_q;
  assign err_count = err_cnt_q;

endmodule
